// File: rtl/fpcmp_pkg.sv
// Shared constants, operand-class struct and helpers for the FloPoCo-format comparator.
package fpcmp_pkg;

    localparam logic [1:0] EXN_ZERO = 2'b00;
    localparam logic [1:0] EXN_NORM = 2'b01;
    localparam logic [1:0] EXN_INF  = 2'b10;
    localparam logic [1:0] EXN_NAN  = 2'b11;

    localparam logic [2:0] CMP_LT    = 3'b000;
    localparam logic [2:0] CMP_LE    = 3'b001;
    localparam logic [2:0] CMP_EQ    = 3'b010;
    localparam logic [2:0] CMP_GE    = 3'b011;
    localparam logic [2:0] CMP_GT    = 3'b100;
    localparam logic [2:0] CMP_NE    = 3'b101;
    localparam logic [2:0] CMP_UNORD = 3'b110;
    localparam logic [2:0] CMP_ORD   = 3'b111;

    // Coarse ordering buckets; normals in the same bucket need the magnitude compare.
    localparam logic [2:0] RANK_NINF  = 3'd0;
    localparam logic [2:0] RANK_NNORM = 3'd1;
    localparam logic [2:0] RANK_ZERO  = 3'd2;
    localparam logic [2:0] RANK_PNORM = 3'd3;
    localparam logic [2:0] RANK_PINF  = 3'd4;

    typedef struct packed {
        logic zero;
        logic neg;
        logic inf;
        logic nan;
    } fpcls_t;

    function automatic int fpcmp_width(input int we, input int wf);
        return we + wf + 3;
    endfunction

    function automatic logic [2:0] fpcmp_rank(input fpcls_t c);
        if (c.inf)       return c.neg ? RANK_NINF : RANK_PINF;
        else if (c.zero) return RANK_ZERO;
        else             return c.neg ? RANK_NNORM : RANK_PNORM;
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational decode of one operand's exception code and sign into class flags.
module fp_classify
    import fpcmp_pkg::*;
(
    input  logic [1:0] exn_i,
    input  logic       sign_i,
    output fpcls_t     cls_o
);

    always_comb begin
        cls_o.zero = (exn_i == EXN_ZERO);
        cls_o.inf  = (exn_i == EXN_INF);
        cls_o.nan  = (exn_i == EXN_NAN);
        cls_o.neg  = sign_i;
    end

endmodule

// File: rtl/fp_compare_pipe.sv
// Two-stage floating-point comparator with valid/ready flow control.
// Optional min/max outputs are built when FPCMP_MINMAX_EN is defined.
module fp_compare_pipe
    import fpcmp_pkg::*;
#(
    parameter int WE    = 11,
    parameter int WF    = 13,
    parameter int TAG_W = 8,
    localparam int W    = fpcmp_width(WE, WF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [2:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_res,
    output logic             out_lt,
    output logic             out_eq,
    output logic             out_gt,
    output logic             out_unord,
`ifdef FPCMP_MINMAX_EN
    output logic [W-1:0]     out_min,
    output logic [W-1:0]     out_max,
`endif
    output logic [TAG_W-1:0] out_tag
);

    localparam int MW   = WE + WF;
    localparam int LO_W = MW / 2;
    localparam int HI_W = MW - LO_W;

    logic   adv;
    logic   [2:1] vld_q;
    fpcls_t a_cls, b_cls;

    assign adv       = !vld_q[2] | out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_q[2];

    fp_classify u_cls_a (.exn_i(in_a[W-1:W-2]), .sign_i(in_a[W-3]), .cls_o(a_cls));
    fp_classify u_cls_b (.exn_i(in_b[W-1:W-2]), .sign_i(in_b[W-3]), .cls_o(b_cls));

    // ---------------- stage 1 ----------------
    logic [HI_W-1:0] a_hi, b_hi;
    logic [LO_W-1:0] a_lo, b_lo;
    assign a_hi = in_a[MW-1:LO_W];
    assign b_hi = in_b[MW-1:LO_W];
    assign a_lo = in_a[LO_W-1:0];
    assign b_lo = in_b[LO_W-1:0];

    fpcls_t           s1_a_cls_q, s1_b_cls_q;
    logic             s1_hi_lt_q, s1_hi_eq_q, s1_lo_lt_q, s1_lo_eq_q;
    logic [2:0]       s1_op_q;
    logic [TAG_W-1:0] s1_tag_q;
`ifdef FPCMP_MINMAX_EN
    logic [W-1:0]     s1_a_q, s1_b_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q[1]   <= 1'b0;
            s1_a_cls_q <= '0;
            s1_b_cls_q <= '0;
            s1_hi_lt_q <= 1'b0;
            s1_hi_eq_q <= 1'b0;
            s1_lo_lt_q <= 1'b0;
            s1_lo_eq_q <= 1'b0;
            s1_op_q    <= '0;
            s1_tag_q   <= '0;
`ifdef FPCMP_MINMAX_EN
            s1_a_q     <= '0;
            s1_b_q     <= '0;
`endif
        end else if (adv) begin
            vld_q[1]   <= in_valid;
            s1_a_cls_q <= a_cls;
            s1_b_cls_q <= b_cls;
            s1_hi_lt_q <= a_hi < b_hi;
            s1_hi_eq_q <= a_hi == b_hi;
            s1_lo_lt_q <= a_lo < b_lo;
            s1_lo_eq_q <= a_lo == b_lo;
            s1_op_q    <= in_op;
            s1_tag_q   <= in_tag;
`ifdef FPCMP_MINMAX_EN
            s1_a_q     <= in_a;
            s1_b_q     <= in_b;
`endif
        end
    end

    // ---------------- stage 2 ----------------
    logic       lt_d, eq_d, gt_d, unord_d, res_d;
    logic       mag_lt, mag_eq;
    logic [2:0] rank_a, rank_b;

    always_comb begin
        rank_a  = fpcmp_rank(s1_a_cls_q);
        rank_b  = fpcmp_rank(s1_b_cls_q);
        mag_lt  = s1_hi_lt_q | (s1_hi_eq_q & s1_lo_lt_q);
        mag_eq  = s1_hi_eq_q & s1_lo_eq_q;
        unord_d = s1_a_cls_q.nan | s1_b_cls_q.nan;
        lt_d    = 1'b0;
        eq_d    = 1'b0;
        gt_d    = 1'b0;
        if (!unord_d) begin
            if (rank_a != rank_b) begin
                lt_d = rank_a < rank_b;
                gt_d = !lt_d;
            end else if (rank_a == RANK_PNORM) begin
                eq_d = mag_eq;
                lt_d = mag_lt;
                gt_d = !mag_lt & !mag_eq;
            end else if (rank_a == RANK_NNORM) begin
                // larger magnitude is the smaller value
                eq_d = mag_eq;
                gt_d = mag_lt;
                lt_d = !mag_lt & !mag_eq;
            end else begin
                eq_d = 1'b1;
            end
        end
        case (s1_op_q)
            CMP_LT:    res_d = lt_d;
            CMP_LE:    res_d = lt_d | eq_d;
            CMP_EQ:    res_d = eq_d;
            CMP_GE:    res_d = gt_d | eq_d;
            CMP_GT:    res_d = gt_d;
            CMP_NE:    res_d = !eq_d;
            CMP_UNORD: res_d = unord_d;
            default:   res_d = !unord_d;
        endcase
    end

`ifdef FPCMP_MINMAX_EN
    logic [W-1:0] min_d, max_d;

    always_comb begin
        min_d = s1_a_q;
        max_d = s1_a_q;
        if (s1_a_cls_q.nan && !s1_b_cls_q.nan) begin
            min_d = s1_b_q;
            max_d = s1_b_q;
        end else if (s1_a_cls_q.nan || s1_b_cls_q.nan) begin
            min_d = s1_a_q;
            max_d = s1_a_q;
        end else if (s1_a_cls_q.zero && s1_b_cls_q.zero
                     && (s1_a_cls_q.neg != s1_b_cls_q.neg)) begin
            min_d = s1_a_cls_q.neg ? s1_a_q : s1_b_q;
            max_d = s1_a_cls_q.neg ? s1_b_q : s1_a_q;
        end else if (lt_d) begin
            min_d = s1_a_q;
            max_d = s1_b_q;
        end else if (gt_d) begin
            min_d = s1_b_q;
            max_d = s1_a_q;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q[2]  <= 1'b0;
            out_res   <= 1'b0;
            out_lt    <= 1'b0;
            out_eq    <= 1'b0;
            out_gt    <= 1'b0;
            out_unord <= 1'b0;
            out_tag   <= '0;
`ifdef FPCMP_MINMAX_EN
            out_min   <= '0;
            out_max   <= '0;
`endif
        end else if (adv) begin
            vld_q[2]  <= vld_q[1];
            out_res   <= res_d;
            out_lt    <= lt_d;
            out_eq    <= eq_d;
            out_gt    <= gt_d;
            out_unord <= unord_d;
            out_tag   <= s1_tag_q;
`ifdef FPCMP_MINMAX_EN
            out_min   <= min_d;
            out_max   <= max_d;
`endif
        end
    end

endmodule

// File: tb/tb_fp_compare_pipe.sv
// Directed self-checking bench for fp_compare_pipe (WE=11, WF=13, TAG_W=8).
// Min/max checks are compiled in when FPCMP_MINMAX_EN is defined.
module tb_fp_compare_pipe;
    import fpcmp_pkg::*;

    localparam int W = 27;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] in_a, in_b;
    logic [2:0]   in_op;
    logic [7:0]   in_tag, out_tag;
    logic         out_res, out_lt, out_eq, out_gt, out_unord;
`ifdef FPCMP_MINMAX_EN
    logic [W-1:0] out_min, out_max;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fp_compare_pipe #(.WE(11), .WF(13), .TAG_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_lt(out_lt), .out_eq(out_eq),
        .out_gt(out_gt), .out_unord(out_unord),
`ifdef FPCMP_MINMAX_EN
        .out_min(out_min), .out_max(out_max),
`endif
        .out_tag(out_tag)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic [1:0] e, input logic s,
                                        input logic [10:0] x, input logic [12:0] f);
        return {e, s, x, f};
    endfunction

    // One isolated transaction; checks latency and all result fields.
    task automatic send(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] op, input logic [7:0] tg, input logic res,
                        input logic [3:0] rel, input logic [W-1:0] mn, input logic [W-1:0] mx);
        @(negedge clk);
        in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_tag = tg;
        @(posedge clk);
        @(negedge clk);
        chk({nm, ".lat1"}, out_valid, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({nm, ".valid"}, out_valid, 1'b1);
        chk({nm, ".res"}, out_res, res);
        chk({nm, ".rel"}, {out_lt, out_eq, out_gt, out_unord}, rel);
        chk({nm, ".tag"}, out_tag, tg);
`ifdef FPCMP_MINMAX_EN
        chk({nm, ".min"}, out_min, mn);
        chk({nm, ".max"}, out_max, mx);
`else
        if (mn !== mx) begin end
`endif
    endtask

    localparam logic [3:0] R_LT = 4'b1000, R_EQ = 4'b0100, R_GT = 4'b0010, R_UN = 4'b0001;

    logic [W-1:0] one, two, pz, nz, nan, ninf, pinf, n1, n2, one_f1, n1_f1;

    initial begin
        one    = mk(2'b01, 1'b0, 11'h3FF, 13'h0);
        two    = mk(2'b01, 1'b0, 11'h400, 13'h0);
        one_f1 = mk(2'b01, 1'b0, 11'h3FF, 13'h1);
        pz     = mk(2'b00, 1'b0, 11'h000, 13'h0);
        nz     = mk(2'b00, 1'b1, 11'h005, 13'h3);
        nan    = mk(2'b11, 1'b0, 11'h000, 13'h0);
        ninf   = mk(2'b10, 1'b1, 11'h000, 13'h0);
        pinf   = mk(2'b10, 1'b0, 11'h123, 13'h7);
        n1     = mk(2'b01, 1'b1, 11'h3FF, 13'h0);
        n1_f1  = mk(2'b01, 1'b1, 11'h3FF, 13'h1);
        n2     = mk(2'b01, 1'b1, 11'h400, 13'h0);

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_op = '0; in_tag = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.valid", out_valid, 1'b0);
        chk("rst.rel", {out_res, out_lt, out_eq, out_gt, out_unord}, 5'b0);
        chk("rst.tag", out_tag, 8'h0);
        chk("rst.ready", in_ready, 1'b1);
`ifdef FPCMP_MINMAX_EN
        chk("rst.minmax", {out_min, out_max}, '0);
`endif
        rst = 1'b0;

        send("le12",   one,  two, CMP_LE,    8'h01, 1'b1, R_LT, one,  two);
        send("gt12",   one,  two, CMP_GT,    8'h02, 1'b0, R_LT, one,  two);
        send("zeq",    pz,   nz,  CMP_EQ,    8'h03, 1'b1, R_EQ, nz,   pz);
        send("nan_ne", nan,  one, CMP_NE,    8'h04, 1'b1, R_UN, one,  one);
        send("nan_un", nan,  one, CMP_UNORD, 8'h05, 1'b1, R_UN, one,  one);
        send("nan_lt", nan,  one, CMP_LT,    8'h06, 1'b0, R_UN, one,  one);
        send("nan_ge", nan,  one, CMP_GE,    8'h07, 1'b0, R_UN, one,  one);
        send("nan2",   nan,  nan, CMP_ORD,   8'h08, 1'b0, R_UN, nan,  nan);
        send("ninf",   ninf, n1,  CMP_LT,    8'h09, 1'b1, R_LT, ninf, n1);
        send("neg2",   n2,   n1,  CMP_GT,    8'h0A, 1'b0, R_LT, n2,   n1);
        send("lo_gt",  one_f1, one, CMP_GT,  8'h0B, 1'b1, R_GT, one,  one_f1);
        send("nlo_lt", n1_f1, n1, CMP_LT,    8'h0C, 1'b1, R_LT, n1_f1, n1);
        send("pinf",   pinf, two, CMP_GE,    8'h0D, 1'b1, R_GT, two,  pinf);
        send("tie",    one,  one, CMP_EQ,    8'h0E, 1'b1, R_EQ, one,  one);
        send("zneg",   nz,   n1,  CMP_GT,    8'h0F, 1'b1, R_GT, n1,   nz);

        // Streaming with backpressure pattern 1,0,0,1 on out_ready.
        begin
            int ti = 0, ri = 0, cyc = 0;
            logic prev_stall = 1'b0;
            logic [12:0] prev_out = '0;
            while (ri < 16 && cyc < 200) begin
                @(negedge clk);
                out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                in_valid  = (ti < 16);
                in_a      = mk(2'b01, 1'b0, 11'h3FF, 13'(ti));
                in_b      = mk(2'b01, 1'b0, 11'h3FF, 13'h7);
                in_op     = CMP_LT;
                in_tag    = 8'(ti);
                #1;
                chk("st.ready", in_ready, !out_valid || out_ready);
                if (prev_stall) begin
                    chk("st.hold_v", out_valid, 1'b1);
                    chk("st.hold", {out_tag, out_res, out_lt, out_eq, out_gt, out_unord}, prev_out);
                end
                if (out_valid && out_ready) begin
                    chk("st.tag", out_tag, 8'(ri));
                    chk("st.res", out_res, ri < 7);
                    ri++;
                end
                if (in_valid && in_ready) ti++;
                prev_stall = out_valid && !out_ready;
                prev_out   = {out_tag, out_res, out_lt, out_eq, out_gt, out_unord};
                cyc++;
            end
            chk("st.count", 64'(ri), 64'd16);
            @(negedge clk);
            in_valid = 1'b0; out_ready = 1'b1;
            @(negedge clk);
            chk("st.nodup", out_valid, 1'b0);
        end

        // Reset with two transactions in flight.
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; in_a = one; in_b = two; in_op = CMP_LT; in_tag = 8'hA1;
        @(negedge clk);
        in_tag = 8'hA2;
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("mrst.valid", out_valid, 1'b0);
        chk("mrst.tag", out_tag, 8'h0);
        chk("mrst.ready", in_ready, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mrst.stale", out_valid, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
